// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder: assembles UART RX bytes into register-file and ALU commands.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder #(
   parameter int ADDR_W = 4,
   parameter logic [7:0] RF_WR_CMD = 8'hAA,
   parameter logic [7:0] RF_RD_CMD = 8'hBB,
   parameter logic [7:0] ALU_OP_CMD = 8'hCC,
   parameter logic [7:0] ALU_NOP_CMD = 8'hDD
`ifdef CMD_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        RX_P_DATA,
   input  logic              RX_D_VLD,
   input  logic              RX_PAR_ERR,
   input  logic              RX_STP_ERR,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] RF_Address,
   output logic [7:0]        RF_WrData,
   output logic              RF_WrEn,
   output logic              RF_RdEn,
   output logic [3:0]        ALU_FUN,
   output logic              ALU_EN,
   output logic              ALU_Gate_EN,
   output logic              cmd_abort
);
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F,
      ISSUE_WR, ISSUE_RD, ISSUE_OPA, ISSUE_OPB, ISSUE_ALU
   } state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0] data_q, data_d, opa_q, opa_d, opb_q, opb_d;
   logic [3:0] fun_q, fun_d;
   logic ops_q, ops_d, gate_q, gate_d, abort_q, abort_d;
   logic waiting, take, timeout;
   assign waiting = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F};
   assign take = RX_D_VLD && (waiting || state_q == IDLE);
`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign timeout = waiting && !take && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
   assign cnt_d = (waiting && !take && !timeout) ? cnt_q + 1'b1 : '0;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      data_d = data_q;
      opa_d = opa_q;
      opb_d = opb_q;
      fun_d = fun_q;
      ops_d = ops_q;
      gate_d = gate_q;
      abort_d = 1'b0;
      if ((take && (RX_PAR_ERR || RX_STP_ERR)) || timeout) begin
         state_d = IDLE;
         abort_d = 1'b1;
         gate_d = 1'b0;
      end else if (take) begin
         case (state_q)
            IDLE: begin
               if (RX_P_DATA == RF_WR_CMD) state_d = WR_ADDR;
               else if (RX_P_DATA == RF_RD_CMD) state_d = RD_ADDR;
               else if (RX_P_DATA == ALU_OP_CMD || RX_P_DATA == ALU_NOP_CMD) begin
                  ops_d = RX_P_DATA == ALU_OP_CMD;
                  state_d = ops_d ? ALU_A : ALU_F;
                  gate_d = 1'b1;
               end else abort_d = 1'b1;
            end
            WR_ADDR: begin addr_d = RX_P_DATA[ADDR_W-1:0]; state_d = WR_DATA; end
            WR_DATA: begin data_d = RX_P_DATA; state_d = ISSUE_WR; end
            RD_ADDR: begin addr_d = RX_P_DATA[ADDR_W-1:0]; state_d = ISSUE_RD; end
            ALU_A: begin opa_d = RX_P_DATA; state_d = ALU_B; end
            ALU_B: begin opb_d = RX_P_DATA; state_d = ALU_F; end
            ALU_F: begin fun_d = RX_P_DATA[3:0]; state_d = ops_q ? ISSUE_OPA : ISSUE_ALU; end
            default: ;
         endcase
      end else if (cmd_ready) begin
         // bytes arriving during ISSUE states fall through here and are dropped
         case (state_q)
            ISSUE_WR, ISSUE_RD: state_d = IDLE;
            ISSUE_OPA: state_d = ISSUE_OPB;
            ISSUE_OPB: state_d = ISSUE_ALU;
            ISSUE_ALU: begin state_d = IDLE; gate_d = 1'b0; end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         addr_q <= '0;
         data_q <= '0;
         opa_q <= '0;
         opb_q <= '0;
         fun_q <= '0;
         ops_q <= 1'b0;
         gate_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         data_q <= data_d;
         opa_q <= opa_d;
         opb_q <= opb_d;
         fun_q <= fun_d;
         ops_q <= ops_d;
         gate_q <= gate_d;
         abort_q <= abort_d;
      end
   end
   assign RF_WrEn = cmd_ready && state_q inside {ISSUE_WR, ISSUE_OPA, ISSUE_OPB};
   assign RF_RdEn = cmd_ready && state_q == ISSUE_RD;
   assign ALU_EN = cmd_ready && state_q == ISSUE_ALU;
   assign RF_Address = state_q == ISSUE_OPA ? '0 : state_q == ISSUE_OPB ? ADDR_W'(1) : addr_q;
   assign RF_WrData = state_q == ISSUE_OPA ? opa_q : state_q == ISSUE_OPB ? opb_q : data_q;
   assign ALU_FUN = fun_q;
   assign ALU_Gate_EN = gate_q;
   assign cmd_abort = abort_q;
endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// tb_uart_rx_cmd_decoder: byte-stream reference model feeding a scoreboard, checked by a monitor.
module tb_uart_rx_cmd_decoder;
   localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_AB = 3;
   typedef struct {
      int kind;
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] fun;
   } ev_t;
   logic CLK = 1'b0, RST = 1'b0;
   logic [7:0] RX_P_DATA = '0;
   logic RX_D_VLD = 1'b0, RX_PAR_ERR = 1'b0, RX_STP_ERR = 1'b0, cmd_ready = 1'b0;
   logic [3:0] RF_Address, ALU_FUN;
   logic [7:0] RF_WrData;
   logic RF_WrEn, RF_RdEn, ALU_EN, ALU_Gate_EN, cmd_abort;
   int total = 0, bad = 0;
   bit rand_rdy = 0;
   ev_t exp_q[$];
   logic [7:0] mbuf[$];

   uart_rx_cmd_decoder dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR), .cmd_ready(cmd_ready),
      .RF_Address(RF_Address), .RF_WrData(RF_WrData), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
      .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_Gate_EN(ALU_Gate_EN), .cmd_abort(cmd_abort)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      #1;
      if (rand_rdy) cmd_ready = $urandom_range(0, 3) != 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [3:0] addr, input logic [7:0] data, input logic [3:0] fun);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.fun = fun;
      exp_q.push_back(e);
   endtask

   // command lengths by opcode: AA 3, BB 2, CC 4, DD 2; anything else aborts
   task automatic model_byte(input logic [7:0] b, input int err);
      int need;
      logic [7:0] a1, a2, a3;
      if (err != 0) begin
         push(K_AB, 0, 0, 0);
         mbuf.delete();
         return;
      end
      mbuf.push_back(b);
      need = mbuf[0] == 8'hAA ? 3 : mbuf[0] == 8'hBB ? 2 : mbuf[0] == 8'hCC ? 4 : mbuf[0] == 8'hDD ? 2 : 0;
      if (need == 0) begin
         push(K_AB, 0, 0, 0);
         mbuf.delete();
      end else if (mbuf.size() == need) begin
         a1 = mbuf[1];
         a2 = need > 2 ? mbuf[2] : 8'h0;
         a3 = need > 3 ? mbuf[3] : 8'h0;
         if (mbuf[0] == 8'hAA) push(K_WR, a1[3:0], a2, 0);
         else if (mbuf[0] == 8'hBB) push(K_RD, a1[3:0], 0, 0);
         else if (mbuf[0] == 8'hCC) begin
            push(K_WR, 4'd0, a1, 0);
            push(K_WR, 4'd1, a2, 0);
            push(K_ALU, 0, 0, a3[3:0]);
         end else push(K_ALU, 0, 0, a1[3:0]);
         mbuf.delete();
      end
   endtask

   task automatic drive(input logic [7:0] b, input int err);
      RX_P_DATA = b;
      RX_D_VLD = 1'b1;
      RX_PAR_ERR = err == 1;
      RX_STP_ERR = err == 2;
      @(posedge CLK);
      #1;
      RX_D_VLD = 1'b0;
      RX_PAR_ERR = 1'b0;
      RX_STP_ERR = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int err);
      model_byte(b, err);
      drive(b, err);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      int c;
      c = 0;
      do begin
         @(posedge CLK);
         c++;
      end while (exp_q.size() != 0 && c < 300);
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   function automatic logic [31:0] outs();
      return {11'd0, RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, ALU_Gate_EN, cmd_abort};
   endfunction

   always @(negedge CLK) begin
      if (RST && (RF_WrEn || RF_RdEn || ALU_EN || cmd_abort)) begin
         ev_t e;
         int kind;
         kind = cmd_abort ? K_AB : ALU_EN ? K_ALU : RF_RdEn ? K_RD : K_WR;
         chk("one_event", int'(RF_WrEn) + int'(RF_RdEn) + int'(ALU_EN) + int'(cmd_abort), 1);
         if (ALU_EN) chk("gate_on_alu", ALU_Gate_EN, 1);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, 32'hFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("kind", kind, e.kind);
            if (e.kind == K_WR || e.kind == K_RD) chk("addr", RF_Address, e.addr);
            if (e.kind == K_WR) chk("wdata", RF_WrData, e.data);
            if (e.kind == K_ALU) chk("fun", ALU_FUN, e.fun);
         end
      end
   end

   initial begin
      logic [7:0] b[4];
      int k, n, ebi;
      bit ok;
      #2;
      chk("reset_outs", outs(), 0);
      idle(3);
      RST = 1'b1;
      cmd_ready = 1'b1;
      idle(2);
      send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
      @(negedge CLK);
      chk("wr_latency", RF_WrEn, 1);
      chk("wr_addr5", RF_Address, 5);
      @(negedge CLK);
      chk("wr_single", RF_WrEn, 0);
      drain();
      cmd_ready = 1'b0;
      send(8'hBB, 0); send(8'h07, 0);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (RF_RdEn !== 1'b0 || RF_Address !== 4'd7) ok = 0;
         if (i == 4) begin
            @(posedge CLK);
            #1;
            drive(8'hAA, 0);
         end
      end
      chk("rd_hold", ok, 1);
      @(posedge CLK);
      #1;
      cmd_ready = 1'b1;
      drain();
      send(8'hBB, 0); send(8'hF3, 0);
      drain();
      send(8'hCC, 0);
      @(negedge CLK);
      chk("gate_after_cc", ALU_Gate_EN, 1);
      @(posedge CLK);
      #1;
      send(8'h12, 0); send(8'h34, 0); send(8'h02, 0);
      @(negedge CLK); chk("opa_we", RF_WrEn, 1);
      @(negedge CLK); chk("opb_we", RF_WrEn, 1);
      @(negedge CLK); chk("alu_en", ALU_EN, 1); chk("gate_during_alu", ALU_Gate_EN, 1);
      @(negedge CLK); chk("gate_off", ALU_Gate_EN, 0);
      drain();
      send(8'hAA, 0); send(8'h05, 1);
      drain();
      send(8'h5A, 0);
      drain();
      send(8'hDD, 0); send(8'h01, 0);
      drain();
      send(8'hCC, 2);
      drain();
      chk("gate_after_err", ALU_Gate_EN, 0);
      send(8'hCC, 0); send(8'h12, 0);
      #3;
      chk("gate_pre_reset", ALU_Gate_EN, 1);
      RST = 1'b0;
      mbuf.delete();
      #1;
      chk("async_reset_outs", outs(), 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      send(8'hAA, 0); send(8'h09, 0); send(8'h77, 0);
      drain();
      send(8'hAA, 0);
      idle(20);
      send(8'h05, 0); send(8'h3C, 0);
      drain();
      rand_rdy = 1;
      for (int it = 0; it < 80; it++) begin
         k = $urandom_range(0, 4);
         b[0] = k == 0 ? 8'hAA : k == 1 ? 8'hBB : k == 2 ? 8'hCC : k == 3 ? 8'hDD : 8'h00;
         if (k == 4) begin
            b[0] = 8'($urandom);
            while (b[0] inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b[0] = 8'($urandom);
         end
         for (int i = 1; i < 4; i++) b[i] = 8'($urandom);
         n = k == 0 ? 3 : k == 2 ? 4 : k == 4 ? 1 : 2;
         ebi = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, n - 1)) : -1;
         for (int i = 0; i < n; i++) begin
            send(b[i], i == ebi ? int'($urandom_range(1, 2)) : 0);
            if (i == ebi) break;
            if (i < n - 1) idle($urandom_range(0, 3));
         end
         drain();
      end
      rand_rdy = 0;
      idle(3);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Consumes bytes from the UART receiver (P_DATA / data_valid / par_err / stp_err) and assembles them into system commands.
- Decoded commands drive register-file write/read strobes and ALU enable/function, with a ready handshake from the downstream controller.
- Gates the ALU clock only while an ALU command is pending; sits directly downstream of the UART RX top in the receive clock domain.

Parameters:
- ADDR_W, 4, register-file address width.
- RF_WR_CMD, 8'hAA, opcode: write (addr, data).
- RF_RD_CMD, 8'hBB, opcode: read (addr).
- ALU_OP_CMD, 8'hCC, opcode: ALU with operands (opA, opB, fun).
- ALU_NOP_CMD, 8'hDD, opcode: ALU without operands (fun).
- TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles (used only with the optional feature).

Ports:
- CLK  in  1  receive/system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid in that cycle.
- RX_PAR_ERR  in  1  parity error for the byte; sampled with RX_D_VLD.
- RX_STP_ERR  in  1  stop error for the byte; sampled with RX_D_VLD.
- cmd_ready  in  1  downstream can accept a strobe this cycle.
- RF_Address  out  ADDR_W  register-file address.
- RF_WrData  out  8  register-file write data.
- RF_WrEn  out  1  write strobe.
- RF_RdEn  out  1  read strobe.
- ALU_FUN  out  4  ALU function, taken from fun byte [3:0].
- ALU_EN  out  1  ALU strobe.
- ALU_Gate_EN  out  1  ALU clock-gate enable.
- cmd_abort  out  1  one-cycle pulse: command discarded.

Behaviour:
- Reset (RST=0, async): state=IDLE; all outputs 0; holding registers 0.
- Byte acceptance:
  - A byte is accepted only in a byte-wait state with RX_D_VLD=1.
  - An accepted byte with RX_PAR_ERR|RX_STP_ERR set: state->IDLE, cmd_abort pulses the next cycle, no strobe is issued.
- States and transitions:
  - IDLE: AA->WR_ADDR; BB->RD_ADDR; CC->ALU_A (ALU_Gate_EN=1); DD->ALU_F (ALU_Gate_EN=1); any other byte-> IDLE with cmd_abort pulse.
  - WR_ADDR: latch addr[ADDR_W-1:0] (upper bits ignored) -> WR_DATA.
  - WR_DATA: latch data -> ISSUE_WR.
  - RD_ADDR: latch addr -> ISSUE_RD.
  - ALU_A: latch opA -> ALU_B.
  - ALU_B: latch opB -> ALU_F.
  - ALU_F: latch fun[3:0]. Next state is ISSUE_OPA if entered via CC, ISSUE_ALU if entered via DD.
  - ISSUE_WR / ISSUE_RD: drive RF_Address and RF_WrData (write only); strobe = cmd_ready. Leave for IDLE on the edge where cmd_ready=1.
  - ISSUE_OPA: RF_Address=0, RF_WrData=opA, RF_WrEn=cmd_ready -> ISSUE_OPB.
  - ISSUE_OPB: RF_Address=1, RF_WrData=opB, RF_WrEn=cmd_ready -> ISSUE_ALU.
  - ISSUE_ALU: ALU_EN=cmd_ready; on cmd_ready -> IDLE, and ALU_Gate_EN drops the same edge.
- Strobe rules:
  - Every strobe is exactly one cycle, and never two strobes in one cycle.
  - Latency: the first strobe appears in the cycle after the final byte's RX_D_VLD cycle if cmd_ready=1; otherwise it is held off until cmd_ready=1.
  - While cmd_ready=0, address/data/FUN are held stable.
- RX_D_VLD during any ISSUE state: byte dropped, no state change, no abort.
- ALU_Gate_EN: registered; 1 from the edge after the CC/DD opcode until leaving ISSUE_ALU or aborting.
- cmd_abort is registered and lasts one cycle.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_F.
  - It clears on entry to those states and on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: state->IDLE, cmd_abort pulses, ALU_Gate_EN drops.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Undefined: no counter; a partial command waits indefinitely.

Test Plan:
- Write command: bytes AA,05,3C with cmd_ready=1 -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=8'h3C, one cycle after the 3C valid; state returns to IDLE.
- Read command with backpressure: BB,07 with cmd_ready=0 for 10 cycles -> RF_RdEn stays 0 and RF_Address holds 7; RF_RdEn pulses once in the first cycle cmd_ready=1.
- ALU with operands: CC,12,34,02 -> RF_WrEn (addr0=12h), then RF_WrEn (addr1=34h), then ALU_EN with ALU_FUN=2, on three consecutive ready cycles; ALU_Gate_EN is 1 from after CC until after ALU_EN.
- Errors: AA,05 with RX_PAR_ERR=1 on byte 05 -> cmd_abort pulse, no strobe, state IDLE. Then byte 5A -> cmd_abort; then DD,01 -> ALU_EN with FUN=1.
- Reset mid-command: RST low after CC,12 -> all outputs 0 immediately (async); after release, decoding restarts at IDLE.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: AA then idle 16 cycles -> cmd_abort pulse, state IDLE. Without the macro: same stimulus then 05,3C -> normal write.
